// File: rtl/ro_puf_if.sv
// Host-side challenge/response handshake of the RO PUF engine.
// The host is master; the engine is slave.
interface ro_puf_if #(
  parameter int RESP_BITS = 8
) ();
  logic                 start;
  logic [7:0]           chall_in;
  logic                 resp_ack;
  logic                 busy;
  logic                 resp_valid;
  logic [RESP_BITS-1:0] response;
  logic [RESP_BITS-1:0] resp_unstable;

  modport master (
    output start, chall_in, resp_ack,
    input  busy, resp_valid,
    input  response, resp_unstable
  );

  modport slave (
    input  start, chall_in, resp_ack,
    output busy, resp_valid,
    output response, resp_unstable
  );
endinterface

// File: rtl/ro_puf_engine.sv
// RO PUF controller: LFSR pair select, windowed edge
// counting, majority voting and instability flags.
module ro_puf_engine #(
  parameter int NUM_RO    = 16,
  parameter int RESP_BITS = 8,
  parameter int WINDOW    = 32,
  parameter int CNT_W     = 8,
  parameter int VOTES     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_RO-1:0] ro_in,
  output logic              ro_en,
  ro_puf_if.slave           host
);

  localparam int HALF    = NUM_RO / 2;
  localparam int SEL_RAW = $clog2(HALF);
  localparam int SEL_W   = (SEL_RAW > 8) ? 8 : SEL_RAW;
  localparam int IDX_W   = $clog2(NUM_RO);
  localparam int WIN_W   = $clog2(WINDOW);
  localparam int VOT_W   = $clog2(VOTES + 1);
  localparam int BIT_W   = $clog2(RESP_BITS + 1);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    IDLE, LOAD, MEASURE, COMPARE, SHIFT, DONE
  } state_t;

  state_t               state_q, state_d;
  logic [7:0]           chall_q, chall_d;
  logic [7:0]           lfsr_q, lfsr_d;
  logic [CNT_W-1:0]     cnt_a_q, cnt_a_d;
  logic [CNT_W-1:0]     cnt_b_q, cnt_b_d;
  logic [WIN_W-1:0]     win_q, win_d;
  logic [VOT_W-1:0]     votes_q, votes_d;
  logic [VOT_W-1:0]     ones_q, ones_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [RESP_BITS-1:0] resp_q, resp_d;
  logic [RESP_BITS-1:0] unst_q, unst_d;
  logic [NUM_RO-1:0]    ro_q, ro_d;
  logic                 busy_q, busy_d;
  logic                 valid_q, valid_d;
  logic                 en_q, en_d;

  logic [NUM_RO-1:0]    rise;
  logic [IDX_W-1:0]     idx_a, idx_b;
  logic                 vote_bit, maj_bit, unst_bit;
  logic                 fb;

  always_comb begin
    state_d  = state_q;
    chall_d  = chall_q;
    lfsr_d   = lfsr_q;
    cnt_a_d  = cnt_a_q;
    cnt_b_d  = cnt_b_q;
    win_d    = win_q;
    votes_d  = votes_q;
    ones_d   = ones_q;
    bit_d    = bit_q;
    resp_d   = resp_q;
    unst_d   = unst_q;
    ro_d     = ro_in;
    rise     = ro_in & ~ro_q;
    idx_a    = IDX_W'(lfsr_q[SEL_W-1:0]);
    idx_b    = IDX_W'(HALF)
             + IDX_W'(lfsr_q[7:8-SEL_W]);
    vote_bit = (cnt_a_q > cnt_b_q);
    maj_bit  = (ones_q > VOT_W'(VOTES / 2));
    unst_bit = (ones_q != '0)
             && (ones_q != VOT_W'(VOTES));
    fb       = lfsr_q[7] ^ lfsr_q[5]
             ^ lfsr_q[4] ^ lfsr_q[3];

    unique case (state_q)
      IDLE: begin
        if (host.start) begin
          chall_d = host.chall_in;
          state_d = LOAD;
        end
      end
      LOAD: begin
        // a zero seed would lock the LFSR
        lfsr_d  = (chall_q == 8'h00) ? 8'hA5 : chall_q;
        cnt_a_d = '0;
        cnt_b_d = '0;
        win_d   = '0;
        votes_d = '0;
        ones_d  = '0;
        bit_d   = '0;
        resp_d  = '0;
        unst_d  = '0;
        state_d = MEASURE;
      end
      MEASURE: begin
        if (rise[idx_a] && cnt_a_q != CNT_MAX)
          cnt_a_d = cnt_a_q + 1'b1;
        if (rise[idx_b] && cnt_b_q != CNT_MAX)
          cnt_b_d = cnt_b_q + 1'b1;
        if (win_q == WIN_W'(WINDOW - 1)) begin
          win_d   = '0;
          state_d = COMPARE;
        end else begin
          win_d = win_q + 1'b1;
        end
      end
      COMPARE: begin
        ones_d  = ones_q + VOT_W'(vote_bit);
        votes_d = votes_q + 1'b1;
        cnt_a_d = '0;
        cnt_b_d = '0;
        if (votes_q == VOT_W'(VOTES - 1))
          state_d = SHIFT;
        else
          state_d = MEASURE;
      end
      SHIFT: begin
        resp_d  = {resp_q[RESP_BITS-2:0], maj_bit};
        unst_d  = {unst_q[RESP_BITS-2:0], unst_bit};
        lfsr_d  = {lfsr_q[6:0], fb};
        ones_d  = '0;
        votes_d = '0;
        bit_d   = bit_q + 1'b1;
        if (bit_q == BIT_W'(RESP_BITS - 1))
          state_d = DONE;
        else
          state_d = MEASURE;
      end
      DONE: begin
        if (host.resp_ack) begin
          state_d = IDLE;
        end else if (host.start) begin
          chall_d = host.chall_in;
          state_d = LOAD;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d  = (state_d != IDLE) && (state_d != DONE);
    en_d    = (state_d == LOAD) || (state_d == MEASURE)
           || (state_d == COMPARE) || (state_d == SHIFT);
    valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      chall_q <= '0;
      lfsr_q  <= '0;
      cnt_a_q <= '0;
      cnt_b_q <= '0;
      win_q   <= '0;
      votes_q <= '0;
      ones_q  <= '0;
      bit_q   <= '0;
      resp_q  <= '0;
      unst_q  <= '0;
      ro_q    <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      chall_q <= chall_d;
      lfsr_q  <= lfsr_d;
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
      win_q   <= win_d;
      votes_q <= votes_d;
      ones_q  <= ones_d;
      bit_q   <= bit_d;
      resp_q  <= resp_d;
      unst_q  <= unst_d;
      ro_q    <= ro_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      en_q    <= en_d;
    end
  end

  assign ro_en              = en_q;
  assign host.busy          = busy_q;
  assign host.resp_valid    = valid_q;
  assign host.response      = resp_q;
  assign host.resp_unstable = unst_q;

endmodule

// File: tb/tb_ro_puf_engine.sv
// Randomised self-checking bench for ro_puf_engine
// against a challenge-level response model.
module tb_ro_puf_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ro_in;
  logic [15:0] fm;
  logic        ph = 1'b0;
  logic        ro_en;
  logic [3:0]  ro2;
  logic        ro_en2;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  always @(negedge clk) begin
    ph    = ~ph;
    ro_in = fm & {16{ph}};
  end

  ro_puf_if #(.RESP_BITS(8)) h ();
  ro_puf_if #(.RESP_BITS(4)) h2 ();

  ro_puf_engine dut (
    .clk   (clk),
    .rst   (rst),
    .ro_in (ro_in),
    .ro_en (ro_en),
    .host  (h)
  );

  ro_puf_engine #(
    .NUM_RO(4), .RESP_BITS(4), .WINDOW(8),
    .CNT_W(8), .VOTES(3)
  ) dut2 (
    .clk   (clk),
    .rst   (rst),
    .ro_in (ro2),
    .ro_en (ro_en2),
    .host  (h2)
  );

  // Each RO either toggles every cycle (16 rises per
  // 32-cycle window) or is static; ties vote 0.
  function automatic logic [7:0] model(
    input logic [7:0] ch, input logic [15:0] m);
    int l, a, b, fb;
    logic [7:0] r;
    l = (ch == 8'h00) ? 'hA5 : int'(ch);
    r = 8'h00;
    for (int i = 0; i < 8; i++) begin
      a = l % 8;
      b = 8 + l / 32;
      r = {r[6:0], m[a] & ~m[b]};
      fb = ((l >> 7) ^ (l >> 5) ^ (l >> 4) ^ (l >> 3)) & 1;
      l = ((l * 2) % 256) + fb;
    end
    return r;
  endfunction

  task automatic run_job(input logic [7:0] ch,
                         input bit poke,
                         output int lat,
                         output bit busy_ok);
    @(negedge clk);
    h.chall_in = ch;
    h.start    = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    busy_ok = 1'b1;
    while (!h.resp_valid && lat < 1000) begin
      if (!h.busy || !ro_en) busy_ok = 1'b0;
      @(negedge clk);
      h.start    = poke && (lat == 100);
      h.chall_in = 8'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    h.start = 1'b0;
  endtask

  task automatic do_ack();
    @(negedge clk);
    h.resp_ack = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    h.resp_ack = 1'b0;
  endtask

  task automatic check_run(input string nm,
                           input logic [7:0] ch,
                           input logic [7:0] exp_r,
                           input bit poke);
    int lat;
    bit bok;
    run_job(ch, poke, lat, bok);
    vectors++;
    if (lat !== 801) begin
      errors++;
      $display("FAIL %s latency got %0d exp 801", nm, lat);
    end
    vectors++;
    if (!bok) begin
      errors++;
      $display("FAIL %s busy/ro_en dropped got 0 exp 1", nm);
    end
    vectors++;
    if (h.response !== exp_r) begin
      errors++;
      $display("FAIL %s response got %h exp %h",
               nm, h.response, exp_r);
    end
    vectors++;
    if (h.resp_unstable !== 8'h00) begin
      errors++;
      $display("FAIL %s unstable got %h exp 00",
               nm, h.resp_unstable);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    vectors++;
    if ({h.busy, h.resp_valid, ro_en,
         h.response, h.resp_unstable} !== 19'd0) begin
      errors++;
      $display("FAIL reset outputs got %b/%b/%b/%h/%h exp 0",
               h.busy, h.resp_valid, ro_en,
               h.response, h.resp_unstable);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_b_fast();
    fm = 16'hFF00;
    check_run("b_fast", 8'h3C, 8'h00, 1'b0);
    do_ack();
  endtask

  task automatic test_a_fast_hold();
    logic ok;
    fm = 16'h00FF;
    check_run("a_fast", 8'h5A, 8'hFF, 1'b0);
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (!h.resp_valid || h.response !== 8'hFF) ok = 1'b0;
    end
    vectors++;
    if (!ok) begin
      errors++;
      $display("FAIL hold valid=%b resp=%h exp 1/FF",
               h.resp_valid, h.response);
    end
    @(negedge clk);
    h.resp_ack = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (h.busy !== 1'b0 || h.resp_valid !== 1'b0
        || h.response !== 8'hFF) begin
      errors++;
      $display("FAIL ack busy=%b valid=%b resp=%h exp 0/0/FF",
               h.busy, h.resp_valid, h.response);
    end
    @(negedge clk);
    h.resp_ack = 1'b0;
  endtask

  task automatic test_tie_a5();
    logic [15:0] m;
    fm = 16'hFFFF;
    check_run("tie", 8'h00, 8'h00, 1'b0);
    do_ack();
    for (int k = 0; k < 3; k++) begin
      m  = 16'($urandom);
      fm = m;
      check_run("a5_seq", 8'h00, model(8'h00, m), 1'b0);
      do_ack();
    end
  endtask

  task automatic test_random();
    logic [7:0]  ch;
    logic [15:0] m;
    for (int k = 0; k < 4; k++) begin
      ch = 8'($urandom);
      m  = 16'($urandom);
      fm = m;
      check_run("random", ch, model(ch, m), 1'b0);
      do_ack();
    end
  endtask

  task automatic test_small();
    int  e;
    logic v;
    @(negedge clk);
    h2.chall_in = 8'h5;
    h2.start    = 1'b1;
    ro2         = 4'h0;
    @(posedge clk); #1;
    e = 0;
    while (!h2.resp_valid && e < 500) begin
      @(negedge clk);
      h2.start = 1'b0;
      v = 1'((e + 1) & 1);
      if (((e % 28) / 9) == 0) ro2 = {2'b00, v, v};
      else                     ro2 = {v, v, 2'b00};
      @(posedge clk); #1;
      e++;
    end
    vectors++;
    if (e !== 113) begin
      errors++;
      $display("FAIL small latency got %0d exp 113", e);
    end
    vectors++;
    if (h2.response !== 4'h0 || h2.resp_unstable !== 4'hF) begin
      errors++;
      $display("FAIL small resp/unst got %h/%h exp 0/F",
               h2.response, h2.resp_unstable);
    end
    @(negedge clk);
    h2.resp_ack = 1'b1;
    @(negedge clk);
    h2.resp_ack = 1'b0;
  endtask

  task automatic test_async_rst();
    fm = 16'h00FF;
    @(negedge clk);
    h.chall_in = 8'h77;
    h.start    = 1'b1;
    @(negedge clk);
    h.start = 1'b0;
    repeat (299) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    vectors++;
    if ({h.busy, h.resp_valid, ro_en,
         h.response, h.resp_unstable} !== 19'd0) begin
      errors++;
      $display("FAIL async_rst got %b/%b/%b/%h/%h exp 0",
               h.busy, h.resp_valid, ro_en,
               h.response, h.resp_unstable);
    end
    @(negedge clk);
    rst = 1'b0;
    check_run("restart", 8'h77, 8'hFF, 1'b0);
    do_ack();
  endtask

  task automatic test_back_to_back();
    logic [7:0]  c1, c2;
    logic [15:0] m;
    int vcnt;
    c1 = 8'($urandom);
    c2 = c1 ^ 8'h81;
    m  = 16'($urandom);
    fm = m;
    check_run("busy_start", c1, model(c1, m), 1'b1);
    check_run("done_start", c2, model(c2, m), 1'b0);
    @(negedge clk);
    h.start    = 1'b1;
    h.resp_ack = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (h.busy !== 1'b0 || h.resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL ack_wins busy=%b valid=%b exp 0/0",
               h.busy, h.resp_valid);
    end
    @(negedge clk);
    h.start    = 1'b0;
    h.resp_ack = 1'b0;
    vcnt = 0;
    repeat (850) begin
      @(posedge clk); #1;
      if (h.resp_valid || h.busy) vcnt++;
    end
    vectors++;
    if (vcnt !== 0) begin
      errors++;
      $display("FAIL ignored_start active cycles %0d exp 0",
               vcnt);
    end
  endtask

  initial begin
    fm          = 16'h0000;
    ro2         = 4'h0;
    h.start     = 1'b0;
    h.chall_in  = 8'h00;
    h.resp_ack  = 1'b0;
    h2.start    = 1'b0;
    h2.chall_in = 8'h00;
    h2.resp_ack = 1'b0;
    test_reset();
    test_b_fast();
    test_a_fast_hold();
    test_tie_a5();
    test_random();
    test_small();
    test_async_rst();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
